// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   state_e : arbiter FSM states (ARB = normal arbitration, LOCK = debug only)
//   owner_e : owner of an outstanding read
//   MEMOP_* : MemOp encodings shared with the memory (size / sign)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  localparam logic [2:0] MEMOP_B  = 3'b000;  // signed byte
  localparam logic [2:0] MEMOP_H  = 3'b001;  // signed half
  localparam logic [2:0] MEMOP_W  = 3'b010;  // word
  localparam logic [2:0] MEMOP_BU = 3'b100;  // unsigned byte
  localparam logic [2:0] MEMOP_HU = 3'b101;  // unsigned half

  // Bits needed to hold the values 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// mem_arb_starve_ctr
// Saturating counter of how long the debug port has been denied.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   inc      : count up one (holds at MAX)
//   clr      : clear to zero (wins over inc)
//   at_max   : counter has reached MAX
// -----------------------------------------------------------------------------
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = cnt_width(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates the unified instruction/data memory between the CPU port and a
// debug/loader port. Single-beat accesses; CPU wins by default, debug wins
// after MAX_WAIT denied cycles of contention. dbg_lock puts the arbiter in a
// debug-only LOCK state.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cpu_req/we/memop/addrsrc/addr/wd CPU request and payload
//   cpu_gnt, cpu_rvalid, cpu_rdata   CPU grant and read return
//   dbg_req/we/memop/addr/wd         debug request and payload
//   dbg_lock                         request exclusive debug ownership
//   dbg_gnt, dbg_rvalid, dbg_rdata   debug grant and read return
//   mem_we/memop/addrsrc/addr/wd     to memory (zero when nothing granted)
//   mem_rd                           memory read data, one cycle after access
//   locked                           FSM is in LOCK
// Optional (define MEM_ARB_PERF_EN):
//   cpu_wait_cycles, dbg_wait_cycles cycles with req=1 and gnt=0
//   grant_count                      total grants
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_memop,
  input  logic              cpu_addrsrc,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [2:0]        dbg_memop,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wd,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [2:0]        mem_memop,
  output logic              mem_addrsrc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              locked
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       cpu_wait_cycles,
  output logic [31:0]       dbg_wait_cycles,
  output logic [31:0]       grant_count
`endif
);

  state_e            state, state_nxt;
  owner_e            rd_owner;
  logic              starve_max;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  // Next state, grants and memory mux. Grants are suppressed during reset so
  // no access reaches memory in a reset cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt   = state;
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    mem_we      = 1'b0;
    mem_memop   = '0;
    mem_addrsrc = 1'b0;
    mem_addr    = '0;
    mem_wd      = '0;

    unique case (state)
      ARB: begin
        if (dbg_lock) state_nxt = LOCK;
        if (!rst) begin
          if (cpu_req && dbg_req) begin
            dbg_gnt = starve_max;
            cpu_gnt = !starve_max;
          end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
          end
        end
      end
      LOCK: begin
        if (!dbg_lock) state_nxt = ARB;
        dbg_gnt = dbg_req && !rst;
      end
      default: state_nxt = ARB;
    endcase

    if (cpu_gnt) begin
      mem_we      = cpu_we;
      mem_memop   = cpu_memop;
      mem_addrsrc = cpu_addrsrc;
      mem_addr    = cpu_addr;
      mem_wd      = cpu_wd;
    end else if (dbg_gnt) begin
      mem_we      = dbg_we;
      mem_memop   = dbg_memop;
      mem_addrsrc = 1'b1;  // debug accesses always go through the data path
      mem_addr    = dbg_addr;
      mem_wd      = dbg_wd;
    end
  end

  assign locked = (state == LOCK);

  // ---------------------------------------------------------------------------
  // Debug starvation counter
  // ---------------------------------------------------------------------------
  mem_arb_starve_ctr #(
    .MAX (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (dbg_req && !dbg_gnt),
    .clr    (dbg_gnt),
    .at_max (starve_max)
  );

  // ---------------------------------------------------------------------------
  // Read return: remember who issued a read so the data one cycle later is
  // steered to that port, independent of any state change in between.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)                    rd_owner <= OWN_NONE;
    else if (cpu_gnt && !cpu_we) rd_owner <= OWN_CPU;
    else if (dbg_gnt && !dbg_we) rd_owner <= OWN_DBG;
    else                        rd_owner <= OWN_NONE;
  end

  // A reset cycle swallows any read still in flight.
  assign cpu_rvalid = (rd_owner == OWN_CPU) && !rst;
  assign dbg_rvalid = (rd_owner == OWN_DBG) && !rst;

  // rdata passes mem_rd through while valid and otherwise holds the last
  // returned value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rd;
      if (dbg_rvalid) dbg_rdata_q <= mem_rd;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rd : cpu_rdata_q;
  assign dbg_rdata = dbg_rvalid ? mem_rd : dbg_rdata_q;

`ifdef MEM_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap modulo 2^32)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_wait_cycles <= '0;
      dbg_wait_cycles <= '0;
      grant_count     <= '0;
    end else begin
      if (cpu_req && !cpu_gnt) cpu_wait_cycles <= cpu_wait_cycles + 32'd1;
      if (dbg_req && !dbg_gnt) dbg_wait_cycles <= dbg_wait_cycles + 32'd1;
      if (cpu_gnt || dbg_gnt)  grant_count     <= grant_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter with a small synchronous memory model.
// Table-driven vectors cover starvation, debug writes and lock; hand-written
// sequences cover the first read, reset mid-operation and alternating reads.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] CW = 32'h1111_1111;  // CPU wd on reads
  localparam logic [31:0] DW = 32'h2222_2222;  // debug wd on reads

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_addrsrc;
  logic [2:0]  cpu_memop;
  logic [31:0] cpu_addr, cpu_wd;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [2:0]  dbg_memop;
  logic [31:0] dbg_addr, dbg_wd;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_we, mem_addrsrc;
  logic [2:0]  mem_memop;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        locked;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] cpu_wait_cycles, dbg_wait_cycles, grant_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_memop   (cpu_memop),
    .cpu_addrsrc (cpu_addrsrc),
    .cpu_addr    (cpu_addr),
    .cpu_wd      (cpu_wd),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_memop   (dbg_memop),
    .dbg_addr    (dbg_addr),
    .dbg_wd      (dbg_wd),
    .dbg_lock    (dbg_lock),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .mem_we      (mem_we),
    .mem_memop   (mem_memop),
    .mem_addrsrc (mem_addrsrc),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd),
    .locked      (locked)
`ifdef MEM_ARB_PERF_EN
    ,
    .cpu_wait_cycles (cpu_wait_cycles),
    .dbg_wait_cycles (dbg_wait_cycles),
    .grant_count     (grant_count)
`endif
  );

  // Memory model: 64 words, registered read (data valid the cycle after).
  logic        mem_init;
  logic [31:0] mem [0:63];
  logic [31:0] mem_rd_q;
  assign mem_rd = mem_rd_q;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | i;
      mem[4]  <= 32'hDEAD_BEEF;   // 0x10
      mem[8]  <= 32'hCAFE_F00D;   // 0x20
      mem[12] <= 32'h0BAD_C0DE;   // 0x30
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wd;
    end
    mem_rd_q <= mem[mem_addr[7:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    cpu_req = 0; cpu_we = 0; cpu_memop = MEMOP_W; cpu_addrsrc = 0;
    cpu_addr = '0; cpu_wd = '0;
    dbg_req = 0; dbg_we = 0; dbg_memop = MEMOP_W; dbg_addr = '0; dbg_wd = '0;
    dbg_lock = 0;
  endtask

  // Drive just after the rising edge; checks happen at the following falling edge.
  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " cpu_gnt"},    32'(cpu_gnt),     32'h0);
    check({tag, " dbg_gnt"},    32'(dbg_gnt),     32'h0);
    check({tag, " cpu_rvalid"}, 32'(cpu_rvalid),  32'h0);
    check({tag, " dbg_rvalid"}, 32'(dbg_rvalid),  32'h0);
    check({tag, " mem_we"},     32'(mem_we),      32'h0);
    check({tag, " mem_addr"},   mem_addr,         32'h0);
    check({tag, " mem_wd"},     mem_wd,           32'h0);
    check({tag, " mem_memop"},  32'(mem_memop),   32'h0);
    check({tag, " mem_addrsrc"},32'(mem_addrsrc), 32'h0);
    check({tag, " locked"},     32'(locked),      32'h0);
    check({tag, " cpu_rdata"},  cpu_rdata,        32'h0);
    check({tag, " dbg_rdata"},  dbg_rdata,        32'h0);
  endtask

  typedef struct {
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wd;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wd;
    logic        dbg_lock;
    logic        e_cg, e_dg, e_we;
    logic [31:0] e_addr;
    logic        e_src;
    logic [31:0] e_wd;
    logic        e_lk, e_crv, e_drv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Starvation: both read continuously; pattern CPU x4, DBG x1, repeated.
    vecs.push_back('{H,L,32'h20,CW, H,L,32'h30,DW, L, H,L,L,32'h20,L,CW, L, L,L,32'h0});
    vecs.push_back('{H,L,32'h20,CW, H,L,32'h30,DW, L, H,L,L,32'h20,L,CW, L, H,L,32'hCAFE_F00D});
    vecs.push_back('{H,L,32'h20,CW, H,L,32'h30,DW, L, H,L,L,32'h20,L,CW, L, H,L,32'hCAFE_F00D});
    vecs.push_back('{H,L,32'h20,CW, H,L,32'h30,DW, L, H,L,L,32'h20,L,CW, L, H,L,32'hCAFE_F00D});
    vecs.push_back('{H,L,32'h20,CW, H,L,32'h30,DW, L, L,H,L,32'h30,H,DW, L, H,L,32'hCAFE_F00D});
    vecs.push_back('{H,L,32'h20,CW, H,L,32'h30,DW, L, H,L,L,32'h20,L,CW, L, L,H,32'h0BAD_C0DE});
    vecs.push_back('{H,L,32'h20,CW, H,L,32'h30,DW, L, H,L,L,32'h20,L,CW, L, H,L,32'hCAFE_F00D});
    vecs.push_back('{H,L,32'h20,CW, H,L,32'h30,DW, L, H,L,L,32'h20,L,CW, L, H,L,32'hCAFE_F00D});
    vecs.push_back('{H,L,32'h20,CW, H,L,32'h30,DW, L, H,L,L,32'h20,L,CW, L, H,L,32'hCAFE_F00D});
    vecs.push_back('{H,L,32'h20,CW, H,L,32'h30,DW, L, L,H,L,32'h30,H,DW, L, H,L,32'hCAFE_F00D});
    // Debug word write to 0x40, then CPU reads it back.
    vecs.push_back('{L,L,32'h0,32'h0, H,H,32'h40,32'h1234_5678, L, L,H,H,32'h40,H,32'h1234_5678, L, L,H,32'h0BAD_C0DE});
    vecs.push_back('{H,L,32'h40,CW, L,L,32'h0,32'h0, L, H,L,L,32'h40,L,CW, L, L,L,32'h0});
    vecs.push_back('{L,L,32'h0,32'h0, L,L,32'h0,32'h0, L, L,L,L,32'h0,L,32'h0, L, H,L,32'h1234_5678});
    // Lock with CPU holding its request; outstanding CPU read still returns.
    vecs.push_back('{H,L,32'h10,CW, L,L,32'h0,32'h0, H, H,L,L,32'h10,L,CW, L, L,L,32'h0});
    vecs.push_back('{H,L,32'h10,CW, L,L,32'h0,32'h0, H, L,L,L,32'h0,L,32'h0, H, H,L,32'hDEAD_BEEF});
    vecs.push_back('{H,L,32'h10,CW, H,L,32'h30,DW, H, L,H,L,32'h30,H,DW, H, L,L,32'h0});
    vecs.push_back('{H,L,32'h10,CW, L,L,32'h0,32'h0, L, L,L,L,32'h0,L,32'h0, H, L,H,32'h0BAD_C0DE});
    vecs.push_back('{H,L,32'h10,CW, L,L,32'h0,32'h0, L, H,L,L,32'h10,L,CW, L, L,L,32'h0});
    vecs.push_back('{L,L,32'h0,32'h0, L,L,32'h0,32'h0, L, L,L,L,32'h0,L,32'h0, L, H,L,32'hDEAD_BEEF});

    // ---------------- reset ----------------
    set_idle();
    rst = 1; mem_init = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("in_reset");
    drive_slot();
    rst = 0; mem_init = 0;
    @(negedge clk);
    check_quiet("after_reset");
`ifdef MEM_ARB_PERF_EN
    check("perf grant_count reset", grant_count, 32'h0);
    check("perf cpu_wait reset", cpu_wait_cycles, 32'h0);
`endif

    // ---------------- first CPU read ----------------
    drive_slot();
    cpu_req = 1; cpu_addr = 32'h10;
    @(negedge clk);
    check("rd1 cpu_gnt",    32'(cpu_gnt),    32'h1);
    check("rd1 mem_addr",   mem_addr,        32'h10);
    check("rd1 mem_we",     32'(mem_we),     32'h0);
    check("rd1 cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    drive_slot();
    set_idle();
    @(negedge clk);
    check("rd1 N+1 cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    check("rd1 N+1 cpu_rdata",  cpu_rdata,       32'hDEAD_BEEF);
    check("rd1 N+1 dbg_rvalid", 32'(dbg_rvalid), 32'h0);
    check("rd1 N+1 cpu_gnt",    32'(cpu_gnt),    32'h0);
    drive_slot();
    @(negedge clk);
    check("rd1 N+2 cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    check("rd1 N+2 cpu_rdata hold", cpu_rdata,   32'hDEAD_BEEF);

    // ---------------- table vectors ----------------
    foreach (vecs[i]) begin
      drive_slot();
      cpu_req  = vecs[i].cpu_req;  cpu_we = vecs[i].cpu_we;
      cpu_addr = vecs[i].cpu_addr; cpu_wd = vecs[i].cpu_wd;
      dbg_req  = vecs[i].dbg_req;  dbg_we = vecs[i].dbg_we;
      dbg_addr = vecs[i].dbg_addr; dbg_wd = vecs[i].dbg_wd;
      dbg_lock = vecs[i].dbg_lock;
      @(negedge clk);
      check($sformatf("row%0d cpu_gnt", i),     32'(cpu_gnt),     32'(vecs[i].e_cg));
      check($sformatf("row%0d dbg_gnt", i),     32'(dbg_gnt),     32'(vecs[i].e_dg));
      check($sformatf("row%0d mem_we", i),      32'(mem_we),      32'(vecs[i].e_we));
      check($sformatf("row%0d mem_addr", i),    mem_addr,         vecs[i].e_addr);
      check($sformatf("row%0d mem_addrsrc", i), 32'(mem_addrsrc), 32'(vecs[i].e_src));
      check($sformatf("row%0d mem_wd", i),      mem_wd,           vecs[i].e_wd);
      check($sformatf("row%0d mem_memop", i),   32'(mem_memop),
            (vecs[i].e_cg || vecs[i].e_dg) ? 32'(MEMOP_W) : 32'h0);
      check($sformatf("row%0d locked", i),      32'(locked),      32'(vecs[i].e_lk));
      check($sformatf("row%0d cpu_rvalid", i),  32'(cpu_rvalid),  32'(vecs[i].e_crv));
      check($sformatf("row%0d dbg_rvalid", i),  32'(dbg_rvalid),  32'(vecs[i].e_drv));
      if (vecs[i].e_crv) check($sformatf("row%0d cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
      if (vecs[i].e_drv) check($sformatf("row%0d dbg_rdata", i), dbg_rdata, vecs[i].e_rdata);
    end

    // ---------------- reset mid-operation ----------------
    drive_slot();
    set_idle();
    cpu_req = 1; cpu_addr = 32'h20; dbg_req = 1; dbg_addr = 32'h30; dbg_lock = 1;
    @(negedge clk);
    check("rstmid cpu_gnt", 32'(cpu_gnt), 32'h1);
    drive_slot();
    set_idle();
    rst = 1;
    @(negedge clk);
    check("rstmid N+1 cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    check("rstmid N+1 cpu_gnt",    32'(cpu_gnt),    32'h0);
    drive_slot();
    @(negedge clk);
    check_quiet("rstmid N+2");
    drive_slot();
    rst = 0;
    @(negedge clk);
    check_quiet("rstmid release");

    // ---------------- alternating CPU / debug reads ----------------
    drive_slot();
    cpu_req = 1; cpu_addr = 32'h10; cpu_addrsrc = 1;
    @(negedge clk);
    check("alt A cpu_gnt",     32'(cpu_gnt),     32'h1);
    check("alt A mem_addrsrc", 32'(mem_addrsrc), 32'h1);
    drive_slot();
    set_idle();
    dbg_req = 1; dbg_addr = 32'h20;
    @(negedge clk);
    check("alt B dbg_gnt",    32'(dbg_gnt),    32'h1);
    check("alt B mem_addr",   mem_addr,        32'h20);
    check("alt B cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    check("alt B cpu_rdata",  cpu_rdata,       32'hDEAD_BEEF);
    check("alt B dbg_rvalid", 32'(dbg_rvalid), 32'h0);
    drive_slot();
    set_idle();
    @(negedge clk);
    check("alt C dbg_rvalid", 32'(dbg_rvalid), 32'h1);
    check("alt C dbg_rdata",  dbg_rdata,       32'hCAFE_F00D);
    check("alt C cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    check("alt C cpu_rdata hold", cpu_rdata,   32'hDEAD_BEEF);
    drive_slot();
    @(negedge clk);
    check("alt D dbg_rvalid", 32'(dbg_rvalid), 32'h0);
    check("alt D dbg_rdata hold", dbg_rdata,   32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
